// File: rtl/dma_axi_rd_stream_if.sv
// AXI4 read-address/read-data channels plus the outgoing stream, bundled for the read DMA.
// master is the DMA side; slave is the memory/consumer side.
interface dma_axi_rd_stream_if #(
    parameter int unsigned AXI_ADDR_W = 32,
    parameter int unsigned AXI_DATA_W = 32,
    parameter int unsigned AXI_ID_W   = 1,
    parameter int unsigned AXI_LEN_W  = 8
) ();

    logic [AXI_ID_W-1:0]   m_axi_arid;
    logic [AXI_ADDR_W-1:0] m_axi_araddr;
    logic [AXI_LEN_W-1:0]  m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;

    logic [AXI_ID_W-1:0]   m_axi_rid;
    logic [AXI_DATA_W-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    logic [AXI_DATA_W-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output tdata, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  tdata, tvalid, tlast,
        output tready
    );

endinterface

// File: rtl/dma_axi_rd_stream.sv
// Single-descriptor AXI4 read DMA: splits a transfer into INCR bursts (max length, no 4KB
// crossing) and streams the returned data out with backpressure and a final tlast.
module dma_axi_rd_stream #(
    parameter int unsigned AXI_ADDR_W    = 32,
    parameter int unsigned AXI_DATA_W    = 32,
    parameter int unsigned AXI_ID_W      = 1,
    parameter int unsigned AXI_LEN_W     = 8,
    parameter int unsigned MAX_BURST_LEN = 16,
    parameter int unsigned XFER_LEN_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AXI_ADDR_W-1:0] start_addr,
    input  logic [XFER_LEN_W-1:0] xfer_len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    dma_axi_rd_stream_if.master   bus
);

    localparam int unsigned Bytes     = AXI_DATA_W / 8;
    localparam int unsigned ByteShift = $clog2(Bytes);
    // Wide enough for the remaining length and for the 4KB-boundary beat count.
    localparam int unsigned CntW      = (XFER_LEN_W > 13) ? XFER_LEN_W + 1 : 14;

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

    state_e                state_q, state_d;
    logic [AXI_ADDR_W-1:0] addr_q, addr_d;
    logic [XFER_LEN_W-1:0] rem_q, rem_d;
    logic                  last_q, last_d;
    logic                  error_q, error_d;
    logic                  ar_valid_q, ar_valid_d;
    logic [AXI_ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic [AXI_LEN_W-1:0]  ar_len_q, ar_len_d;
    logic [CntW-1:0]       beats;
    logic [CntW-1:0]       next_beats;
    logic                  beat_ok;

    function automatic logic [CntW-1:0] calc_beats(input logic [AXI_ADDR_W-1:0] addr,
                                                   input logic [XFER_LEN_W-1:0] rem);
        logic [CntW-1:0] bnd;
        logic [CntW-1:0] lim;
        bnd = CntW'((13'd4096 - {1'b0, addr[11:0]}) >> ByteShift);
        lim = CntW'(MAX_BURST_LEN);
        if (CntW'(rem) < lim) lim = CntW'(rem);
        if (bnd < lim) lim = bnd;
        return lim;
    endfunction

    assign beats   = calc_beats(addr_q, rem_q);
    assign beat_ok = (state_q == StData) && bus.m_axi_rvalid && bus.tready;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        last_d     = last_q;
        error_d    = error_q;
        ar_valid_d = ar_valid_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        next_beats = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (xfer_len != '0) begin
                        addr_d     = start_addr;
                        rem_d      = xfer_len;
                        error_d    = 1'b0;
                        next_beats = calc_beats(start_addr, xfer_len);
                        ar_addr_d  = start_addr;
                        ar_len_d   = AXI_LEN_W'(next_beats - CntW'(1));
                        ar_valid_d = 1'b1;
                        state_d    = StAddr;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StAddr: begin
                if (ar_valid_q && bus.m_axi_arready) begin
                    addr_d     = addr_q + (AXI_ADDR_W'(beats) << ByteShift);
                    rem_d      = rem_q - XFER_LEN_W'(beats);
                    last_d     = (CntW'(rem_q) == beats);
                    ar_valid_d = 1'b0;
                    state_d    = StData;
                end
            end
            StData: begin
                if (beat_ok) begin
                    if (bus.m_axi_rresp != 2'b00) error_d = 1'b1;
                    if (bus.m_axi_rlast) begin
                        if (last_q) begin
                            state_d = StDone;
                        end else begin
                            // addr_q/rem_q already point past the finished burst.
                            next_beats = beats;
                            ar_addr_d  = addr_q;
                            ar_len_d   = AXI_LEN_W'(beats - CntW'(1));
                            ar_valid_d = 1'b1;
                            state_d    = StAddr;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            rem_q      <= '0;
            last_q     <= 1'b0;
            error_q    <= 1'b0;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            last_q     <= last_d;
            error_q    <= error_d;
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
        end
    end

    logic unused_rid;
    logic unused_next_beats;
    assign unused_rid        = ^bus.m_axi_rid;
    assign unused_next_beats = ^next_beats;

    assign busy  = (state_q != StIdle);
    assign done  = (state_q == StDone);
    assign error = error_q;

    assign bus.m_axi_arid    = '0;
    assign bus.m_axi_araddr  = ar_addr_q;
    assign bus.m_axi_arlen   = ar_len_q;
    assign bus.m_axi_arsize  = 3'(ByteShift);
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arvalid = ar_valid_q;

    // Zero-latency pass-through while a burst is being drained.
    assign bus.m_axi_rready = (state_q == StData) && bus.tready;
    assign bus.tvalid       = (state_q == StData) && bus.m_axi_rvalid;
    assign bus.tdata        = bus.m_axi_rdata;
    assign bus.tlast        = (state_q == StData) && bus.m_axi_rlast && last_q;

endmodule

// File: tb/tb_dma_axi_rd_stream.sv
// Scoreboard bench for dma_axi_rd_stream: directed transfers, an AXI slave model and a
// monitor that pops expected AR requests and stream beats as the DUT presents them.
module tb_dma_axi_rd_stream;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned IDW = 1;
    localparam int unsigned LW  = 8;
    localparam int unsigned MBL = 16;
    localparam int unsigned XW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [XW-1:0] xfer_len = '0;
    logic          busy, done, error;

    dma_axi_rd_stream_if #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IDW), .AXI_LEN_W(LW)) bus ();

    dma_axi_rd_stream #(
        .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IDW), .AXI_LEN_W(LW),
        .MAX_BURST_LEN(MBL), .XFER_LEN_W(XW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .xfer_len(xfer_len),
        .busy(busy), .done(done), .error(error), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] addr; logic [7:0] len;} ar_t;
    typedef struct packed {logic [31:0] data; logic last;} beat_t;

    ar_t   exp_ar[$];
    beat_t exp_beat[$];
    ar_t   ea;
    beat_t eb;

    int total = 0;
    int bad = 0;
    int err_beat = 0, ar_delay = 0, stall_beat = 0, stall_cnt = 0;
    int beats_seen = 0, g_beat = 0;
    bit mon_en = 1'b0, done_next = 1'b0, err_next = 1'b0, done_seen = 1'b0;
    bit ar_wait = 1'b0, t_wait = 1'b0, exp_done;
    logic [31:0] prev_araddr, prev_tdata;
    logic [7:0]  prev_arlen;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // AXI slave: drive at negedge, sample handshakes 1 time unit later.
    int          s_st = 0, s_dly = 0, s_idx = 0;
    logic [31:0] s_addr = '0;
    logic [7:0]  s_len = '0;
    bit          ar_fire = 1'b0, r_fire = 1'b0;

    initial begin
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rresp   = 2'b00;
        bus.m_axi_rlast   = 1'b0;
        bus.m_axi_rid     = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                s_st = 0;
                bus.m_axi_arready = 1'b0;
                bus.m_axi_rvalid  = 1'b0;
                bus.m_axi_rlast   = 1'b0;
                ar_fire = 1'b0;
                r_fire  = 1'b0;
            end else begin
                if (ar_fire) begin
                    s_st = 2;
                    s_idx = 0;
                    bus.m_axi_arready = 1'b0;
                end
                if (r_fire) begin
                    g_beat++;
                    if (s_idx == int'(s_len)) begin
                        s_st = 0;
                        bus.m_axi_rvalid = 1'b0;
                        bus.m_axi_rlast  = 1'b0;
                    end else begin
                        s_idx++;
                    end
                end
                if (s_st == 0 && bus.m_axi_arvalid) begin
                    s_dly = ar_delay;
                    s_st = 1;
                end
                if (s_st == 1) begin
                    if (s_dly == 0) bus.m_axi_arready = 1'b1;
                    else s_dly--;
                end
                if (s_st == 2) begin
                    bus.m_axi_rvalid = 1'b1;
                    bus.m_axi_rdata  = mem_word(s_addr + 32'(s_idx * 4));
                    bus.m_axi_rresp  = (g_beat + 1 == err_beat) ? 2'b10 : 2'b00;
                    bus.m_axi_rlast  = (s_idx == int'(s_len));
                end
                #1;
                ar_fire = bus.m_axi_arvalid && bus.m_axi_arready;
                if (ar_fire) begin
                    s_addr = bus.m_axi_araddr;
                    s_len  = bus.m_axi_arlen;
                end
                r_fire = bus.m_axi_rvalid && bus.m_axi_rready;
            end
        end
    end

    initial begin
        bus.tready = 1'b1;
        forever begin
            @(negedge clk);
            if (stall_cnt > 0) begin
                bus.tready = 1'b0;
                stall_cnt--;
            end else begin
                bus.tready = 1'b1;
            end
        end
    end

    // Monitor: samples 2 time units after negedge, well away from posedge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                exp_done = done_next;
                done_next = 1'b0;
                if (done || exp_done) check("done_pulse", 64'(done), 64'(exp_done));
                if (done) done_seen = 1'b1;
                if (err_next) begin
                    check("error_set", 64'(error), 64'd1);
                    err_next = 1'b0;
                end
                if (bus.m_axi_arvalid) begin
                    if (ar_wait) begin
                        check("ar_hold_addr", 64'(bus.m_axi_araddr), 64'(prev_araddr));
                        check("ar_hold_len", 64'(bus.m_axi_arlen), 64'(prev_arlen));
                    end
                    if (bus.m_axi_arready) begin
                        ar_wait = 1'b0;
                        if (exp_ar.size() == 0) begin
                            check("ar_unexpected", 64'(exp_ar.size()), 64'd1);
                        end else begin
                            ea = exp_ar.pop_front();
                            check("araddr", 64'(bus.m_axi_araddr), 64'(ea.addr));
                            check("arlen", 64'(bus.m_axi_arlen), 64'(ea.len));
                        end
                    end else begin
                        ar_wait = 1'b1;
                        prev_araddr = bus.m_axi_araddr;
                        prev_arlen  = bus.m_axi_arlen;
                    end
                end else begin
                    ar_wait = 1'b0;
                end
                if (bus.tvalid) begin
                    check("rready_eq_tready", 64'(bus.m_axi_rready), 64'(bus.tready));
                    if (bus.tready) begin
                        t_wait = 1'b0;
                        beats_seen++;
                        if (exp_beat.size() == 0) begin
                            check("beat_unexpected", 64'(exp_beat.size()), 64'd1);
                        end else begin
                            eb = exp_beat.pop_front();
                            check("tdata", 64'(bus.tdata), 64'(eb.data));
                            check("tlast", 64'(bus.tlast), 64'(eb.last));
                            if (eb.last) done_next = 1'b1;
                        end
                        if (beats_seen == err_beat) err_next = 1'b1;
                        if (beats_seen == stall_beat) stall_cnt = 10;
                    end else begin
                        if (t_wait) check("tdata_hold", 64'(bus.tdata), 64'(prev_tdata));
                        t_wait = 1'b1;
                        prev_tdata = bus.tdata;
                    end
                end else begin
                    t_wait = 1'b0;
                end
            end
        end
    end

    task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
        ar_t r;
        r.addr = a;
        r.len  = l;
        exp_ar.push_back(r);
    endtask

    task automatic run_xfer(input logic [31:0] a, input int n, input int eb_i, input int ad,
                            input int sb, input bit poke, input logic exp_err);
        beat_t b;
        err_beat = eb_i;
        ar_delay = ad;
        stall_beat = sb;
        beats_seen = 0;
        g_beat = 0;
        done_seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            b.data = mem_word(a + 32'(i * 4));
            b.last = (i == n - 1);
            exp_beat.push_back(b);
        end
        @(negedge clk);
        #3;
        start = 1'b1;
        start_addr = a;
        xfer_len = XW'(n);
        if (n == 0) done_next = 1'b1;
        for (int i = 0; i < 3000 && !done_seen; i++) begin
            @(negedge clk);
            #3;
            if (poke && i == 10) begin
                start = 1'b1;
                start_addr = 32'h800;
                xfer_len = 16'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_seen", 64'(done_seen), 64'd1);
        check("ar_q_empty", 64'(exp_ar.size()), 64'd0);
        check("beat_q_empty", 64'(exp_beat.size()), 64'd0);
        check("error_final", 64'(error), 64'(exp_err));
        @(negedge clk);
        #3;
        check("busy_after", 64'(busy), 64'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_arvalid"}, 64'(bus.m_axi_arvalid), 64'd0);
        check({tag, "_araddr"}, 64'(bus.m_axi_araddr), 64'd0);
        check({tag, "_arlen"}, 64'(bus.m_axi_arlen), 64'd0);
        check({tag, "_tvalid"}, 64'(bus.tvalid), 64'd0);
        check({tag, "_rready"}, 64'(bus.m_axi_rready), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #2;
        check_reset("rst");
        check("arsize", 64'(bus.m_axi_arsize), 64'd2);
        check("arburst", 64'(bus.m_axi_arburst), 64'd1);
        check("arid", 64'(bus.m_axi_arid), 64'd0);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Single burst.
        push_ar(32'h100, 8'd4);
        run_xfer(32'h100, 5, 0, 0, 0, 1'b0, 1'b0);

        // Three bursts, tready stall mid-burst, ignored start while busy.
        push_ar(32'h0, 8'd15);
        push_ar(32'h40, 8'd15);
        push_ar(32'h80, 8'd7);
        run_xfer(32'h0, 40, 0, 0, 7, 1'b1, 1'b0);

        // 4KB split with delayed arready.
        push_ar(32'hFF8, 8'd1);
        push_ar(32'h1000, 8'd5);
        run_xfer(32'hFF8, 8, 0, 5, 0, 1'b0, 1'b0);

        // SLVERR on beat 3, then a clean transfer clears error.
        push_ar(32'h200, 8'd4);
        run_xfer(32'h200, 5, 3, 0, 0, 1'b0, 1'b1);
        push_ar(32'h300, 8'd2);
        run_xfer(32'h300, 3, 0, 0, 0, 1'b0, 1'b0);

        // Zero-length descriptor.
        run_xfer(32'h400, 0, 0, 0, 0, 1'b0, 1'b0);

        // Reset in the middle of a transfer.
        mon_en = 1'b0;
        @(negedge clk);
        #3;
        start = 1'b1;
        start_addr = 32'h0;
        xfer_len = 16'd40;
        @(negedge clk);
        #3;
        start = 1'b0;
        repeat (15) @(negedge clk);
        #3;
        rst = 1'b1;
        @(negedge clk);
        #2;
        check_reset("midrst");
        #1;
        rst = 1'b0;
        exp_ar.delete();
        exp_beat.delete();
        done_next = 1'b0;
        err_next = 1'b0;
        ar_wait = 1'b0;
        t_wait = 1'b0;
        stall_cnt = 0;
        mon_en = 1'b1;

        // Recovery; first burst ends exactly on the 4KB boundary.
        push_ar(32'h3FC0, 8'd15);
        push_ar(32'h4000, 8'd3);
        run_xfer(32'h3FC0, 20, 0, 0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
